// File: rtl/pixel_drain_pkg.sv
// Shared Mandelbrot definitions: drain FSM state encoding and the RGB332
// palette used to colour iteration counts.
package pixel_drain_pkg;

  // Drain FSM states (plain constants so older tools/netlists see fixed codes)
  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_ADDR  = 2'd1;
  localparam logic [1:0] ST_WAIT  = 2'd2;
  localparam logic [1:0] ST_WRITE = 2'd3;

  // RGB332 palette: black for points inside the set, then bands by count
  localparam logic [7:0] COLOR_SET   = 8'h00;
  localparam logic [7:0] COLOR_BAND0 = 8'hE0;  // red
  localparam logic [7:0] COLOR_BAND1 = 8'hFC;  // yellow
  localparam logic [7:0] COLOR_BAND2 = 8'h1C;  // green
  localparam logic [7:0] COLOR_BAND3 = 8'h1F;  // cyan
  localparam logic [7:0] COLOR_BAND4 = 8'h03;  // blue

endpackage

// File: rtl/pixel_drain_color_map.sv
// Combinational iteration-count to RGB332 colour lookup.
module color_map
  import pixel_drain_pkg::*;
#(
  parameter int MAX_ITERATIONS = 100
) (
  input  logic [7:0] count,
  output logic [7:0] color
);

  logic [31:0] count_ext;

  assign count_ext = {24'd0, count};

  // Escape limit first, then the bands from the lowest count upward
  always_comb begin
    color = COLOR_BAND4;
    if (count_ext >= 32'(MAX_ITERATIONS)) begin
      color = COLOR_SET;
    end else if (count < 8'd8) begin
      color = COLOR_BAND0;
    end else if (count < 8'd16) begin
      color = COLOR_BAND1;
    end else if (count < 8'd32) begin
      color = COLOR_BAND2;
    end else if (count < 8'd64) begin
      color = COLOR_BAND3;
    end
  end

endmodule

// File: rtl/pixel_drain.sv
// Reads iteration counts out of the partitioned M10K store in raster order
// and writes one coloured pixel per handshake to the VGA pixel sink.
module pixel_drain
  import pixel_drain_pkg::*;
#(
  parameter int PARTITION      = 2,
  parameter int PARTITION_SIZE = 100000,
  parameter int H_PIXELS       = 640,
  parameter int V_PIXELS       = 480,
  parameter int MAX_ITERATIONS = 100
) (
  input  logic                              clk,
  input  logic                              reset,
  input  logic                              start,
  output logic [$clog2(PARTITION_SIZE)-1:0] m10k_read_address,
  input  logic [PARTITION*8-1:0]            m10k_read_data,
  output logic [9:0]                        vga_x,
  output logic [8:0]                        vga_y,
  output logic [7:0]                        vga_color,
  output logic                              vga_write,
  input  logic                              vga_ready,
  output logic                              busy,
  output logic                              frame_done
);

  localparam int ADDR_W   = $clog2(PARTITION_SIZE);
  // Partitions actually touched by one frame; may exceed PARTITION when the
  // store is too small, so the counter must be able to count past it.
  localparam int PART_MAX = (H_PIXELS * V_PIXELS + PARTITION_SIZE - 1) / PARTITION_SIZE;
  localparam int PART_CNT = (PART_MAX > PARTITION) ? PART_MAX : PARTITION;
  localparam int PART_W   = $clog2(PART_CNT + 1);

  logic [1:0]        state_reg, state_next;
  logic [ADDR_W-1:0] addr_reg;
  logic [PART_W-1:0] part_reg;
  logic [9:0]        x_reg;
  logic [8:0]        y_reg;
  logic [7:0]        count_reg;
  logic              in_range_reg;
  logic              frame_done_reg;

  logic [7:0]        part_bytes [PARTITION];
  logic [7:0]        sel_byte;
  logic              sel_hit;
  logic [7:0]        mapped_color;
  logic              handshake;
  logic              last_pixel;

  // Split the packed read bus into one byte lane per partition
  generate
    for (genvar gi = 0; gi < PARTITION; gi++) begin : g_lane
      assign part_bytes[gi] = m10k_read_data[gi*8 +: 8];
    end
  endgenerate

  // Pick the lane for the current partition; out-of-range partitions miss
  always_comb begin
    sel_byte = 8'd0;
    sel_hit  = 1'b0;
    for (int p = 0; p < PARTITION; p++) begin
      if (part_reg == PART_W'(p)) begin
        sel_byte = part_bytes[p];
        sel_hit  = 1'b1;
      end
    end
  end

  assign handshake  = (state_reg == ST_WRITE) && vga_ready;
  assign last_pixel = (x_reg == 10'(H_PIXELS - 1)) && (y_reg == 9'(V_PIXELS - 1));

  // Next-state logic: fixed ADDR/WAIT/WRITE walk per pixel
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      ST_IDLE:  if (start) state_next = ST_ADDR;
      ST_ADDR:  state_next = ST_WAIT;
      ST_WAIT:  state_next = ST_WRITE;
      ST_WRITE: if (handshake) state_next = last_pixel ? ST_IDLE : ST_ADDR;
      default:  state_next = ST_IDLE;
    endcase
  end

  // State register and the one-cycle end-of-frame pulse
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_reg      <= ST_IDLE;
      frame_done_reg <= 1'b0;
    end else begin
      state_reg      <= state_next;
      frame_done_reg <= handshake && last_pixel;
    end
  end

  // Raster and storage position counters, advanced only on an accepted pixel
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      x_reg    <= '0;
      y_reg    <= '0;
      addr_reg <= '0;
      part_reg <= '0;
    end else if (handshake) begin
      if (last_pixel) begin
        x_reg    <= '0;
        y_reg    <= '0;
        addr_reg <= '0;
        part_reg <= '0;
      end else begin
        if (x_reg == 10'(H_PIXELS - 1)) begin
          x_reg <= '0;
          y_reg <= y_reg + 9'd1;
        end else begin
          x_reg <= x_reg + 10'd1;
        end
        if (addr_reg == ADDR_W'(PARTITION_SIZE - 1)) begin
          addr_reg <= '0;
          part_reg <= part_reg + PART_W'(1);
        end else begin
          addr_reg <= addr_reg + ADDR_W'(1);
        end
      end
    end
  end

  // Capture the count once the M10K data is valid and hold it through WRITE
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count_reg    <= 8'd0;
      in_range_reg <= 1'b0;
    end else if (state_reg == ST_WAIT) begin
      count_reg    <= sel_byte;
      in_range_reg <= sel_hit;
    end
  end

  color_map #(
    .MAX_ITERATIONS(MAX_ITERATIONS)
  ) u_color_map (
    .count(count_reg),
    .color(mapped_color)
  );

  assign m10k_read_address = addr_reg;
  assign vga_x             = x_reg;
  assign vga_y             = y_reg;
  assign vga_write         = (state_reg == ST_WRITE);
  assign vga_color         = (vga_write && in_range_reg) ? mapped_color : COLOR_SET;
  assign busy              = (state_reg != ST_IDLE);
  assign frame_done        = frame_done_reg;

endmodule

// File: tb/tb_pixel_drain.sv
// Directed bench for pixel_drain: a two-partition instance and a
// single-partition instance on a 4x2 frame with 4-word partitions.
module tb_pixel_drain;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic        start2;
  logic        vga_ready;

  logic [1:0]  addr1, addr2;
  logic [15:0] rd1;
  logic [7:0]  rd2;
  logic [9:0]  x1, x2;
  logic [8:0]  y1, y2;
  logic [7:0]  c1, c2;
  logic        w1, w2, b1, b2, d1, d2;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int start_edge;

  logic [7:0] mem0 [4];
  logic [7:0] mem1 [4];
  logic [7:0] exp_col1 [8];
  logic [7:0] exp_col2 [8];

  logic [9:0] hx1[$];
  logic [8:0] hy1[$];
  logic [7:0] hc1[$];
  logic [1:0] ha1[$];
  logic [7:0] hc2[$];
  int done1 = 0;
  int done2 = 0;
  int done_cyc1 = 0;

  pixel_drain #(
    .PARTITION(2), .PARTITION_SIZE(4), .H_PIXELS(4), .V_PIXELS(2), .MAX_ITERATIONS(100)
  ) dut1 (
    .clk(clk), .reset(reset), .start(start),
    .m10k_read_address(addr1), .m10k_read_data(rd1),
    .vga_x(x1), .vga_y(y1), .vga_color(c1), .vga_write(w1), .vga_ready(vga_ready),
    .busy(b1), .frame_done(d1)
  );

  pixel_drain #(
    .PARTITION(1), .PARTITION_SIZE(4), .H_PIXELS(4), .V_PIXELS(2), .MAX_ITERATIONS(100)
  ) dut2 (
    .clk(clk), .reset(reset), .start(start2),
    .m10k_read_address(addr2), .m10k_read_data(rd2),
    .vga_x(x2), .vga_y(y2), .vga_color(c2), .vga_write(w2), .vga_ready(vga_ready),
    .busy(b2), .frame_done(d2)
  );

  always #5 clk = ~clk;

  // M10K model with one cycle of registered read latency
  always @(posedge clk) begin
    rd1 <= {mem1[addr1], mem0[addr1]};
    rd2 <= mem0[addr2];
    cyc <= cyc + 1;
  end

  // Transaction monitor: one line per accepted pixel
  always @(negedge clk) begin
    if (w1 && vga_ready) begin
      hx1.push_back(x1);
      hy1.push_back(y1);
      hc1.push_back(c1);
      ha1.push_back(addr1);
      $display("dut1 pixel x=%0d y=%0d color=%02h addr=%0d", x1, y1, c1, addr1);
    end
    if (d1) begin
      done1 = done1 + 1;
      done_cyc1 = cyc;
      $display("dut1 frame_done at cycle %0d", cyc);
    end
    if (w2 && vga_ready) begin
      hc2.push_back(c2);
      $display("dut2 pixel x=%0d y=%0d color=%02h addr=%0d", x2, y2, c2, addr2);
    end
    if (d2) begin
      done2 = done2 + 1;
      $display("dut2 frame_done at cycle %0d", cyc);
    end
  end

  task automatic clear_log();
    hx1.delete(); hy1.delete(); hc1.delete(); ha1.delete(); hc2.delete();
  endtask

  task automatic pulse_start1();
    @(negedge clk);
    start = 1'b1;
    start_edge = cyc + 1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_done1(input int n_before, input string name);
    int k;
    for (k = 0; k < 300; k++) begin
      @(negedge clk);
      if (done1 > n_before) break;
    end
    checks++;
    if (k >= 300) begin
      errors++;
      $display("FAIL %s timeout: frame_done count %0d, required > %0d", name, done1, n_before);
    end
    repeat (2) @(negedge clk);
  endtask

  task automatic check_frame1(input string name);
    checks++;
    if (hx1.size() != 8) begin
      errors++;
      $display("FAIL %s pixel count: got %0d, required 8", name, hx1.size());
    end
    for (int i = 0; i < 8 && i < hx1.size(); i++) begin
      checks++;
      if (hx1[i] !== 10'(i % 4) || hy1[i] !== 9'(i / 4) || hc1[i] !== exp_col1[i]) begin
        errors++;
        $display("FAIL %s pixel %0d: got (%0d,%0d) %02h, required (%0d,%0d) %02h",
                 name, i, hx1[i], hy1[i], hc1[i], i % 4, i / 4, exp_col1[i]);
      end
    end
  endtask

  task automatic test_reset();
    reset = 1'b0; start = 1'b0; start2 = 1'b0; vga_ready = 1'b1;
    repeat (3) @(negedge clk);
    checks++;
    if ({w1, b1, d1} !== 3'b000) begin
      errors++; $display("FAIL reset_flags: got w/b/d=%b, required 000", {w1, b1, d1});
    end
    checks++;
    if (x1 !== 10'd0 || y1 !== 9'd0) begin
      errors++; $display("FAIL reset_xy: got (%0d,%0d), required (0,0)", x1, y1);
    end
    checks++;
    if (c1 !== 8'h00 || addr1 !== 2'd0) begin
      errors++; $display("FAIL reset_color_addr: got %02h/%0d, required 00/0", c1, addr1);
    end
    reset = 1'b1;
    @(negedge clk);
    checks++;
    if (b1 !== 1'b0) begin
      errors++; $display("FAIL idle_after_reset busy: got %b, required 0", b1);
    end
  endtask

  task automatic test_full_drain();
    int n;
    clear_log();
    n = done1;
    pulse_start1();
    wait_done1(n, "full_drain");
    check_frame1("full_drain");
    checks++;
    if (done_cyc1 - start_edge != 24) begin
      errors++;
      $display("FAIL full_drain latency: got %0d cycles, required 24", done_cyc1 - start_edge);
    end
    checks++;
    if (done1 != n + 1 || d1 !== 1'b0 || b1 !== 1'b0) begin
      errors++;
      $display("FAIL full_drain done: got count %0d d=%b busy=%b, required %0d 0 0", done1 - n, d1, b1, 1);
    end
  endtask

  task automatic test_partition_wrap();
    int n;
    clear_log();
    n = done1;
    pulse_start1();
    wait_done1(n, "partition_wrap");
    for (int i = 0; i < 8 && i < ha1.size(); i++) begin
      checks++;
      if (ha1[i] !== 2'(i % 4)) begin
        errors++;
        $display("FAIL partition_wrap addr %0d: got %0d, required %0d", i, ha1[i], i % 4);
      end
    end
    checks++;
    if (hc1.size() < 8 || hc1[3] !== 8'h00 || hc1[4] !== 8'h1F) begin
      errors++;
      $display("FAIL partition_wrap switch: got size %0d, required pixel3=00 pixel4=1F", hc1.size());
    end
  endtask

  task automatic test_backpressure();
    int n;
    int k;
    clear_log();
    n = done1;
    pulse_start1();
    for (k = 0; k < 100; k++) begin
      @(posedge clk); #2;
      if (w1 && x1 == 10'd2 && y1 == 9'd0) break;
    end
    checks++;
    if (k >= 100) begin
      errors++; $display("FAIL backpressure reach: pixel (2,0) not seen, required within 100 cycles");
    end
    vga_ready = 1'b0;
    for (int j = 0; j < 5; j++) begin
      checks++;
      if (w1 !== 1'b1 || x1 !== 10'd2 || y1 !== 9'd0 || c1 !== 8'h1C) begin
        errors++;
        $display("FAIL backpressure hold %0d: got w=%b (%0d,%0d) %02h, required 1 (2,0) 1C", j, w1, x1, y1, c1);
      end
      @(posedge clk); #2;
    end
    vga_ready = 1'b1;
    wait_done1(n, "backpressure");
    check_frame1("backpressure");
  endtask

  task automatic test_reset_mid_frame();
    int n;
    int k;
    clear_log();
    pulse_start1();
    for (k = 0; k < 100; k++) begin
      @(posedge clk); #2;
      if (w1 && x1 == 10'd1 && y1 == 9'd1) break;
    end
    checks++;
    if (k >= 100) begin
      errors++; $display("FAIL reset_mid reach: pixel (1,1) not seen, required within 100 cycles");
    end
    n = done1;
    reset = 1'b0;
    #1;
    checks++;
    if ({w1, b1, d1} !== 3'b000 || x1 !== 10'd0 || y1 !== 9'd0 || c1 !== 8'h00 || addr1 !== 2'd0) begin
      errors++;
      $display("FAIL reset_mid outputs: got w/b/d=%b (%0d,%0d) %02h addr=%0d, required 000 (0,0) 00 0",
               {w1, b1, d1}, x1, y1, c1, addr1);
    end
    repeat (3) @(posedge clk);
    #2 reset = 1'b1;
    repeat (5) @(negedge clk);
    checks++;
    if (done1 != n || b1 !== 1'b0) begin
      errors++; $display("FAIL reset_mid abandon: got done delta %0d busy=%b, required 0 0", done1 - n, b1);
    end
    clear_log();
    pulse_start1();
    wait_done1(n, "reset_mid_restart");
    checks++;
    if (hx1.size() < 1 || hx1[0] !== 10'd0 || hy1[0] !== 9'd0 || hc1[0] !== 8'hE0) begin
      errors++; $display("FAIL reset_mid restart: first pixel not (0,0) E0, size %0d", hx1.size());
    end
    check_frame1("reset_mid_restart");
  endtask

  task automatic test_start_while_busy();
    int n;
    clear_log();
    n = done1;
    pulse_start1();
    for (int j = 0; j < 4; j++) begin
      repeat (4) @(negedge clk);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
    end
    wait_done1(n, "start_busy");
    repeat (10) @(negedge clk);
    checks++;
    if (hx1.size() != 8 || done1 != n + 1 || b1 !== 1'b0) begin
      errors++;
      $display("FAIL start_busy: got %0d writes %0d done busy=%b, required 8 1 0", hx1.size(), done1 - n, b1);
    end
  endtask

  task automatic test_single_partition();
    int n;
    int k;
    clear_log();
    n = done2;
    @(negedge clk);
    start2 = 1'b1;
    @(negedge clk);
    start2 = 1'b0;
    for (k = 0; k < 300; k++) begin
      @(negedge clk);
      if (done2 > n) break;
    end
    checks++;
    if (k >= 300) begin
      errors++; $display("FAIL single_partition timeout: no frame_done");
    end
    repeat (2) @(negedge clk);
    checks++;
    if (hc2.size() != 8) begin
      errors++; $display("FAIL single_partition count: got %0d, required 8", hc2.size());
    end
    for (int i = 0; i < 8 && i < hc2.size(); i++) begin
      checks++;
      if (hc2[i] !== exp_col2[i]) begin
        errors++;
        $display("FAIL single_partition pixel %0d: got %02h, required %02h", i, hc2[i], exp_col2[i]);
      end
    end
  endtask

  initial begin
    mem0[0] = 8'd3;  mem0[1] = 8'd10; mem0[2] = 8'd20; mem0[3] = 8'd100;
    mem1[0] = 8'd50; mem1[1] = 8'd70; mem1[2] = 8'd0;  mem1[3] = 8'd99;
    exp_col1[0] = 8'hE0; exp_col1[1] = 8'hFC; exp_col1[2] = 8'h1C; exp_col1[3] = 8'h00;
    exp_col1[4] = 8'h1F; exp_col1[5] = 8'h03; exp_col1[6] = 8'hE0; exp_col1[7] = 8'h03;
    exp_col2[0] = 8'hE0; exp_col2[1] = 8'hFC; exp_col2[2] = 8'h1C; exp_col2[3] = 8'h00;
    exp_col2[4] = 8'h00; exp_col2[5] = 8'h00; exp_col2[6] = 8'h00; exp_col2[7] = 8'h00;

    test_reset();
    test_full_drain();
    test_partition_wrap();
    test_backpressure();
    test_reset_mid_frame();
    test_start_while_busy();
    test_single_partition();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  // Hard stop in case the design wedges somewhere a loop bound cannot see
  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog expired");
  end

endmodule
